// File: rtl/bp_pkg.sv
// Shared branch-prediction types and defaults used by the feedback queue and its bench.
package bp_pkg;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 30;

    typedef struct packed {
        logic              pred_taken;
        logic [ADDR_W-1:0] alt_pc;
    } entry_t;

endpackage

// File: rtl/bfq_storage.sv
// Entry array for the branch feedback queue: one write port, one asynchronous read port.
module bfq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 31,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_feedback_queue.sv
// In-order queue of outstanding branch predictions; resolves the head against EX,
// trains the saturating counter and flushes younger entries on a mispredict.
module branch_feedback_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH  = bp_pkg::DEPTH,
    parameter int unsigned ADDR_W = bp_pkg::ADDR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic              push_pred_taken,
    input  logic [ADDR_W-1:0] push_pc_fallthru,
    input  logic [ADDR_W-1:0] push_pc_target,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              feedback_valid,
    output logic              set_taken,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              overflow_err,
    output logic              underflow_err
);

    typedef struct packed {
        logic              pred_taken;
        logic [ADDR_W-1:0] alt_pc;
    } bfq_entry_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    bfq_entry_t wr_entry;
    bfq_entry_t head_entry;

    logic push_ok;
    logic pop;
    logic miss;
    logic flush_now;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // The stored PC is the one to recover to if the prediction turns out wrong.
    assign wr_entry.pred_taken = push_pred_taken;
    assign wr_entry.alt_pc     = push_pred_taken ? push_pc_fallthru : push_pc_target;

    assign pop       = resolve_valid & ~empty;
    assign miss      = pop & (head_entry.pred_taken ^ resolve_taken);
    assign flush_now = miss;
    // A push alongside a flush is on the wrong path and is dropped silently.
    assign push_ok   = push_valid & ~full & ~flush_now;

    bfq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 1)
    ) u_storage (
        .clk   (clk),
        .we    (push_ok),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (head_entry)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(push_ok);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            feedback_valid <= 1'b0;
            set_taken      <= 1'b0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            feedback_valid <= pop;
            mispredict     <= miss;
            redirect_pc    <= miss ? head_entry.alt_pc : '0;
            if (pop) begin
                set_taken <= resolve_taken;
            end
            if (push_valid & full & ~flush_now) begin
                overflow_err <= 1'b1;
            end
            if (resolve_valid & empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue at DEPTH=4, ADDR_W=30.
module tb_branch_feedback_queue;
    import bp_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic              push_pred_taken;
    logic [ADDR_W-1:0] push_pc_fallthru;
    logic [ADDR_W-1:0] push_pc_target;
    logic              full;
    logic              empty;
    logic [2:0]        count;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              feedback_valid;
    logic              set_taken;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic              overflow_err;
    logic              underflow_err;

    int total = 0;
    int bad   = 0;

    entry_t exp_q[$];
    entry_t e;

    always #5 clk = ~clk;

    branch_feedback_queue #(
        .DEPTH  (4),
        .ADDR_W (30)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_pred_taken  (push_pred_taken),
        .push_pc_fallthru (push_pc_fallthru),
        .push_pc_target   (push_pc_target),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .feedback_valid   (feedback_valid),
        .set_taken        (set_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic set_push(input logic pred, input logic [ADDR_W-1:0] ft,
                            input logic [ADDR_W-1:0] tg);
        push_valid       = 1'b1;
        push_pred_taken  = pred;
        push_pc_fallthru = ft;
        push_pc_target   = tg;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        push_pred_taken  = 1'b0;
        push_pc_fallthru = '0;
        push_pc_target   = '0;
        resolve_taken    = 1'b0;
        do_reset();
        total++;
        if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_status got cnt=%0d e=%b f=%b want 0 1 0", count, empty, full);
        end
        total++;
        if ({feedback_valid, set_taken, mispredict, redirect_pc, overflow_err, underflow_err}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs got fb=%b st=%b mp=%b pc=%h ov=%b un=%b want all 0",
                     feedback_valid, set_taken, mispredict, redirect_pc, overflow_err,
                     underflow_err);
        end
    endtask

    task automatic test_in_order();
        logic [2:0] preds;
        preds = 3'b101;
        for (int i = 0; i < 3; i++) begin
            set_push(preds[i], 30'h10 + 30'(i), 30'h20 + 30'(i));
            step();
        end
        idle();
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL inorder_count got=%0d want=3", count);
        end
        for (int i = 0; i < 3; i++) begin
            resolve_valid = 1'b1;
            resolve_taken = preds[i];
            step();
            total++;
            if ({feedback_valid, set_taken, mispredict, redirect_pc} !==
                {1'b1, preds[i], 1'b0, 30'h0}) begin
                bad++;
                $display("FAIL inorder_fb%0d got fb=%b st=%b mp=%b pc=%h want 1 %b 0 0",
                         i, feedback_valid, set_taken, mispredict, redirect_pc, preds[i]);
            end
        end
        idle();
        step();
        total++;
        if ({feedback_valid, empty, set_taken} !== 3'b011) begin
            bad++;
            $display("FAIL inorder_drain got fb=%b e=%b st=%b want 0 1 1",
                     feedback_valid, empty, set_taken);
        end
    endtask

    task automatic test_mispredict();
        set_push(1'b1, 30'h100, 30'h200);
        step();
        idle();
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        step();
        idle();
        total++;
        if ({feedback_valid, mispredict, set_taken, redirect_pc} !==
            {1'b1, 1'b1, 1'b0, 30'h100}) begin
            bad++;
            $display("FAIL mispredict got fb=%b mp=%b st=%b pc=%h want 1 1 0 100",
                     feedback_valid, mispredict, set_taken, redirect_pc);
        end
        step();
        total++;
        if ({mispredict, feedback_valid} !== 2'b00) begin
            bad++;
            $display("FAIL mispredict_pulse got mp=%b fb=%b want 0 0", mispredict, feedback_valid);
        end
    endtask

    task automatic test_flush_push();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b0, 30'h30 + 30'(i), 30'h40 + 30'(i));
            step();
        end
        // Head predicted not-taken, resolves taken; a new push arrives the same cycle.
        set_push(1'b1, 30'h77, 30'h88);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        idle();
        total++;
        if ({count, empty, overflow_err} !== {3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL flush_state got cnt=%0d e=%b ov=%b want 0 1 0",
                     count, empty, overflow_err);
        end
        total++;
        if ({mispredict, redirect_pc} !== {1'b1, 30'h40}) begin
            bad++;
            $display("FAIL flush_redirect got mp=%b pc=%h want 1 40", mispredict, redirect_pc);
        end
        // Queue restarts at slot 0 with a fresh entry.
        set_push(1'b1, 30'h55, 30'h66);
        step();
        idle();
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        step();
        idle();
        total++;
        if ({mispredict, redirect_pc, count} !== {1'b1, 30'h55, 3'd0}) begin
            bad++;
            $display("FAIL flush_restart got mp=%b pc=%h cnt=%0d want 1 55 0",
                     mispredict, redirect_pc, count);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        exp_q = {};
        for (int i = 0; i < 4; i++) begin
            set_push(1'(i), 30'h300 + 30'(i), 30'h400 + 30'(i));
            exp_q.push_back({1'(i), (i % 2 == 1) ? 30'h300 + 30'(i) : 30'h400 + 30'(i)});
            step();
        end
        idle();
        total++;
        if ({full, count, overflow_err} !== {1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL full_flag got f=%b cnt=%0d ov=%b want 1 4 0", full, count, overflow_err);
        end
        set_push(1'b1, 30'h3ff, 30'h3fe);
        step();
        idle();
        total++;
        if ({count, overflow_err} !== {3'd4, 1'b1}) begin
            bad++;
            $display("FAIL overflow got cnt=%0d ov=%b want 4 1", count, overflow_err);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            resolve_valid = 1'b1;
            resolve_taken = e.pred_taken;
            step();
        end
        idle();
        total++;
        if (count !== 3'd2) begin
            bad++;
            $display("FAIL drain_two got cnt=%0d want 2", count);
        end
        // Ten push+pop pairs walk both pointers through several wraps.
        for (int i = 4; i < 14; i++) begin
            e = exp_q.pop_front();
            set_push(1'(i), 30'h300 + 30'(i), 30'h400 + 30'(i));
            exp_q.push_back({1'(i), (i % 2 == 1) ? 30'h300 + 30'(i) : 30'h400 + 30'(i)});
            resolve_valid = 1'b1;
            resolve_taken = e.pred_taken;
            step();
            total++;
            if ({count, feedback_valid, mispredict, set_taken} !==
                {3'd2, 1'b1, 1'b0, e.pred_taken}) begin
                bad++;
                $display("FAIL pushpop%0d got cnt=%0d fb=%b mp=%b st=%b want 2 1 0 %b",
                         i, count, feedback_valid, mispredict, set_taken, e.pred_taken);
            end
        end
        idle();
        e = exp_q.pop_front();
        resolve_valid = 1'b1;
        resolve_taken = ~e.pred_taken;
        step();
        idle();
        total++;
        if ({mispredict, redirect_pc, count} !== {1'b1, e.alt_pc, 3'd0}) begin
            bad++;
            $display("FAIL wrap_redirect got mp=%b pc=%h cnt=%0d want 1 %h 0",
                     mispredict, redirect_pc, count, e.alt_pc);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        idle();
        total++;
        if ({feedback_valid, underflow_err, count, set_taken} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL underflow got fb=%b un=%b cnt=%0d st=%b want 0 1 0 0",
                     feedback_valid, underflow_err, count, set_taken);
        end
        step();
        step();
        total++;
        if (underflow_err !== 1'b1) begin
            bad++;
            $display("FAIL underflow_sticky got=%b want=1", underflow_err);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 30'h500 + 30'(i), 30'h600 + 30'(i));
            step();
        end
        set_push(1'b1, 30'h503, 30'h603);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        step();
        idle();
        total++;
        if ({count, set_taken, underflow_err} !== {3'd3, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rst_setup got cnt=%0d st=%b un=%b want 3 1 1",
                     count, set_taken, underflow_err);
        end
        rst           = 1'b1;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        set_push(1'b0, 30'h700, 30'h701);
        step();
        rst = 1'b0;
        idle();
        total++;
        if ({count, empty, feedback_valid, set_taken, mispredict, redirect_pc, overflow_err,
             underflow_err} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid got cnt=%0d e=%b fb=%b st=%b mp=%b pc=%h ov=%b un=%b",
                     count, empty, feedback_valid, set_taken, mispredict, redirect_pc,
                     overflow_err, underflow_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_mispredict();
        test_flush_push();
        test_full_wrap();
        test_underflow();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
